// File: rtl/ring_counter_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : ring_counter_param_if
//  Purpose  : Control/status bundle for the ring_counter_param sequencer.
//             The master drives step control and load data. The slave
//             (the sequencer) returns its state, the wrap pulse and the
//             illegal-state flag.
//  Signals  : en, mode, dir, load, load_val   master -> slave
//             q, wrap, err                    slave  -> master
//  Revision : 1.0  initial release
// ============================================================================
interface ring_counter_param_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             mode;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             wrap;
    logic             err;

    modport master (
        output en, mode, dir, load, load_val,
        input  q, wrap, err
    );

    modport slave (
        input  en, mode, dir, load, load_val,
        output q, wrap, err
    );
endinterface
`default_nettype wire

// File: rtl/ring_counter_param.sv
`default_nettype none
// ============================================================================
//  Module   : ring_counter_param
//  Purpose  : WIDTH-bit shift-ring sequencer. The mode is selectable at run
//             time: ring (one-hot circulate) or Johnson (twisted ring). The
//             direction is also selectable (left or right). The block has a
//             count enable and a synchronous load. It emits a wrap pulse once
//             per period and flags states that are illegal for the current
//             mode. It can optionally force an illegal state back to SEED.
//  Ports    : clk        rising-edge clock
//             rst_n      asynchronous active-low reset
//             bus.en     advance one step
//             bus.mode   0 = ring, 1 = Johnson
//             bus.dir    0 = left (toward MSB), 1 = right (toward LSB)
//             bus.load   synchronous load of bus.load_val, overrides en
//             bus.q      registered state
//             bus.wrap   registered pulse: q has returned to SEED by a shift
//             bus.err    combinational: q is illegal for the current mode
//  Revision : 1.0  initial release
// ============================================================================
module ring_counter_param #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] SEED        = {1'b1, {(WIDTH-1){1'b0}}},
    parameter bit               AUTOCORRECT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ring_counter_param_if.slave   bus
);

    // The counter must hold values up to WIDTH (a popcount).
    localparam int c_CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_shift;
    logic [c_CW-1:0]  w_ones;
    logic [c_CW-1:0]  w_edges;
    logic             w_err;

    // Ring legality needs exactly one set bit.
    // Johnson legality allows at most one 0/1 boundary between adjacent
    // bits. All-zeros and all-ones have no boundary, so both are legal.
    always_comb begin
        w_ones  = '0;
        w_edges = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ones = w_ones + c_CW'(r_q[i]);
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            w_edges = w_edges + c_CW'(r_q[i] ^ r_q[i+1]);
        end
    end

    assign w_err = bus.mode ? (w_edges > c_CW'(1)) : (w_ones != c_CW'(1));

    always_comb begin
        w_shift = r_q;
        case ({bus.mode, bus.dir})
            2'b00:   w_shift = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            2'b01:   w_shift = {r_q[0], r_q[WIDTH-1:1]};
            2'b10:   w_shift = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
            default: w_shift = {~r_q[0], r_q[WIDTH-1:1]};
        endcase
    end

    // Only a genuine shift may raise wrap. A load or a correction that
    // lands on SEED leaves it low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= SEED;
            r_wrap <= 1'b0;
        end else if (bus.load) begin
            r_q    <= bus.load_val;
            r_wrap <= 1'b0;
        end else if (!bus.en) begin
            r_wrap <= 1'b0;
        end else if (w_err && AUTOCORRECT) begin
            r_q    <= SEED;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_shift;
            r_wrap <= (w_shift == SEED);
        end
    end

    assign bus.q    = r_q;
    assign bus.wrap = r_wrap;
    assign bus.err  = w_err;

endmodule
`default_nettype wire

// File: tb/tb_ring_counter_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ring_counter_param
//  Purpose  : Self-checking bench for ring_counter_param. It runs two
//             instances, one with AUTOCORRECT=1 and one with AUTOCORRECT=0,
//             driven by the same stimulus. An arithmetic reference model
//             covers both. The bench applies directed sequences first and
//             then randomized stimulus, including mid-cycle asynchronous
//             resets.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ring_counter_param;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;
    localparam int SEED = 1 << (W - 1);

    logic clk;
    logic rst_n;

    logic         s_en, s_mode, s_dir, s_load;
    logic [W-1:0] s_lv;

    int n_checks;
    int n_errors;

    // Model state: index 0 is AUTOCORRECT=1, index 1 is AUTOCORRECT=0.
    int m_q [2];
    int m_w [2];

    ring_counter_param_if #(.WIDTH(W)) if_ac ();
    ring_counter_param_if #(.WIDTH(W)) if_nc ();

    assign if_ac.en = s_en;   assign if_ac.mode = s_mode; assign if_ac.dir = s_dir;
    assign if_ac.load = s_load; assign if_ac.load_val = s_lv;
    assign if_nc.en = s_en;   assign if_nc.mode = s_mode; assign if_nc.dir = s_dir;
    assign if_nc.load = s_load; assign if_nc.load_val = s_lv;

    ring_counter_param #(.WIDTH(W), .AUTOCORRECT(1'b1)) u_dut_ac (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_ac.slave)
    );

    ring_counter_param #(.WIDTH(W), .AUTOCORRECT(1'b0)) u_dut_nc (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_nc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Legality rule from the mode definition, computed arithmetically.
    function automatic bit legal(input int v, input bit md);
        if (!md) return $countones(v & MASK) == 1;
        return $countones((v ^ (v >> 1)) & (MASK >> 1)) <= 1;
    endfunction

    function automatic int shifted(input int v, input bit md, input bit dr);
        if (!md && !dr) return ((v << 1) & MASK) | ((v >> (W-1)) & 1);
        if (!md &&  dr) return (v >> 1) | ((v & 1) << (W-1));
        if ( md && !dr) return ((v << 1) & MASK) | (((v >> (W-1)) & 1) ^ 1);
        return (v >> 1) | (((v & 1) ^ 1) << (W-1));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_q[k] = SEED;
            m_w[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (s_load) begin
                m_q[k] = int'(s_lv);
                m_w[k] = 0;
            end else if (!s_en) begin
                m_w[k] = 0;
            end else if (k == 0 && !legal(m_q[k], s_mode)) begin
                m_q[k] = SEED;
                m_w[k] = 0;
            end else begin
                m_q[k] = shifted(m_q[k], s_mode, s_dir);
                m_w[k] = (m_q[k] == SEED) ? 1 : 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".q_ac"},    int'(if_ac.q),    m_q[0]);
        check({tag, ".wrap_ac"}, int'(if_ac.wrap), m_w[0]);
        check({tag, ".err_ac"},  int'(if_ac.err),  legal(m_q[0], s_mode) ? 0 : 1);
        check({tag, ".q_nc"},    int'(if_nc.q),    m_q[1]);
        check({tag, ".wrap_nc"}, int'(if_nc.wrap), m_w[1]);
        check({tag, ".err_nc"},  int'(if_nc.err),  legal(m_q[1], s_mode) ? 0 : 1);
    endtask

    task automatic drive(input bit en, input bit md, input bit dr, input bit ld, input int lv);
        s_en = en; s_mode = md; s_dir = dr; s_load = ld; s_lv = W'(lv);
    endtask

    // One clock edge: update the model, then sample 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    int wraps;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        check("reset.q_const", int'(if_ac.q), 8);

        #3 rst_n = 1'b1;

        // Ring left from SEED: 0001,0010,0100,1000, wrap on the last step.
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("ringL");
        check("ringL.q_end", int'(if_ac.q), 8);
        check("ringL.wrap_end", int'(if_ac.wrap), 1);

        // Johnson left: 8-step period with exactly one wrap.
        drive(1, 1, 0, 0, 0);
        wraps = 0;
        for (int i = 0; i < 8; i++) begin
            step("johnL");
            wraps += int'(if_ac.wrap);
        end
        check("johnL.wraps", wraps, 1);
        check("johnL.q_end", int'(if_ac.q), 8);

        // Ring right, with a direction reversal partway through.
        drive(1, 0, 1, 0, 0);
        step("ringR");
        check("ringR.q1", int'(if_ac.q), 4);
        step("ringR");
        drive(1, 0, 0, 0, 0);
        step("ringR.rev");
        check("ringR.rev_q", int'(if_ac.q), 4);
        step("ringR.rev2");

        // Load an illegal ring value, then take one enabled step.
        drive(0, 0, 0, 1, 6);
        step("ld_illegal");
        check("ld_illegal.err", int'(if_ac.err), 1);
        drive(1, 0, 0, 0, 0);
        step("correct");
        check("correct.q_ac",  int'(if_ac.q),   8);
        check("correct.err_ac", int'(if_ac.err), 0);
        check("correct.q_nc",  int'(if_nc.q),   12);
        check("correct.err_nc", int'(if_nc.err), 1);

        // Switching mode exposes illegality immediately (0011 is Johnson-legal).
        drive(0, 1, 0, 1, 3);
        step("ld_j");
        s_mode = 1'b0; #1;
        check("modeflip.err", int'(if_ac.err), 1);

        // Load wins over en, then hold.
        drive(1, 0, 0, 1, 2);
        step("ld_en");
        check("ld_en.q", int'(if_ac.q), 2);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("hold");
        check("hold.q", int'(if_ac.q), 2);

        // Loading SEED does not pulse wrap.
        drive(0, 0, 0, 1, SEED);
        step("ld_seed");
        check("ld_seed.wrap", int'(if_ac.wrap), 0);

        // Asynchronous reset between edges while counting.
        drive(1, 1, 1, 0, 0);
        step("pre_rst");
        step("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        #1 rst_n = 1'b1;

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, MASK));
            if ($urandom_range(0, 49) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                compare_all("rnd_rst");
                #1 rst_n = 1'b1;
            end
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
